interrupt_controller: RTL and testbench
=======================================

Name: interrupt_controller

Overview:
- Upstream companion of the control unit. Collects external interrupt lines and edge-detects them into a pending register.
- Applies a CPU-writable mask and picks the highest-priority pending source.
- Drives the control unit's s_interruption input and supplies the handler vector address to the PC mux.
- Holds the request until the control unit reports handler completion via s_finish_interr, then releases the next source.

Parameters:
- NUM_IRQ, 4, number of external interrupt lines (1..8).
- PC_W, 10, width of the program counter / vector output.
- VEC_BASE, 10'd1000, vector address of source 0.
- VEC_STRIDE, 4, address distance between consecutive source vectors.
- TIMER_PERIOD, 1000, timer interrupt period in cycles (used only with TIMER_IRQ_EN).

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- reset, input, 1, synchronous active-low reset, sampled on rising clk.
- irq_in, input, NUM_IRQ, asynchronous-origin interrupt lines; double-flop synchronised internally, rising edge sets pending.
- mask_we, input, 1, write strobe for the mask register (top-level port decode of we_port).
- mask_data, input, NUM_SRC, new mask value; 1 = source enabled.
- int_ack, input, 1, one-cycle pulse from top level when the control unit executes its INTERR entry (we_istack with s_mux1=0).
- s_finish_interr, input, 1, from control unit; high during FNSH (return-from-interrupt).
- s_interruption, output, 1, interrupt request to the control unit.
- int_vector, output, PC_W, handler address for the PC mux.
- pending, output, NUM_SRC, pending register (debug/readback).
- NUM_SRC = NUM_IRQ, or NUM_IRQ+1 with TIMER_IRQ_EN.

Behaviour:
- Reset (reset==0 at a clk edge): pending=0, mask=0, sync flops=0, state=IDLE, s_interruption=0, int_vector=0, in-service index=0.
- Synchroniser: 2 flops per line, plus a third flop for edge detect.
  - A rising edge sets pending[i] 3 cycles after irq_in[i] rises.
  - Levels held high do not re-trigger; re-triggering needs a low→high transition.
- Set vs clear in the same cycle: a set of pending[i] wins over its clear.
- Mask:
  - mask_we loads mask on the next edge.
  - A masked source still latches pending; it is only excluded from arbitration.
  - Unmasking later raises the request.
- Arbitration: fixed priority, lowest index wins. eligible = pending & mask.
- FSM, 3 states:
  - IDLE:
    - If eligible≠0, latch the winning index into in-service and go REQ next cycle.
    - int_vector = VEC_BASE + idx*VEC_STRIDE, truncated to PC_W, registered on the same edge.
  - REQ:
    - s_interruption=1 and int_vector stable.
    - On int_ack go to SVC.
    - The latched index is frozen; higher-priority arrivals do not preempt (no nesting).
  - SVC:
    - s_interruption stays 1, so the control unit's onInterrupt flag blocks re-entry.
    - On s_finish_interr=1, clear pending[in-service] and go IDLE.
  - IDLE after SVC: s_interruption=0 for at least 1 cycle, so the control unit can clear onInterrupt before the next request.
- Output timing: s_interruption is a registered output, 1 in REQ and SVC only. Latency from pending set to s_interruption=1 is 2 cycles.
- int_ack outside REQ is ignored.
- s_finish_interr outside SVC is ignored.
- Mask writes during REQ/SVC take effect but do not cancel the in-service source.
- Reset mid-service returns to IDLE with everything cleared; no pending interrupt is lost silently except by reset.

Optional Feature:
- Macro: TIMER_IRQ_EN.
- Defined:
  - Adds an internal counter 0..TIMER_PERIOD-1 that wraps to 0.
  - On wrap it sets pending[NUM_IRQ] (lowest priority); mask bit NUM_IRQ enables it.
  - The counter resets to 0 and runs continuously regardless of mask.
  - NUM_SRC = NUM_IRQ+1.
- Undefined: no counter, NUM_SRC = NUM_IRQ, no extra mask/pending bit.

Test Plan:
- Basic: reset, mask=4'b1111, pulse irq_in[2] → pending[2]=1 after 3 cycles; s_interruption=1 2 cycles later; int_vector=1008.
  - Then int_ack, then s_finish_interr → pending=0, s_interruption=0.
- Priority: irq_in[3] and irq_in[1] rise in the same cycle → vector 1004 first; after finish, 1-cycle gap, then vector 1012.
- Masking: mask=4'b1110, pulse irq_in[0] → pending[0]=1, s_interruption stays 0. Write mask=4'b0001 → request with vector 1000.
- No nesting: during SVC of source 2, pulse irq_in[0] → int_vector stays 1008, pending[0]=1. Finish → next request vector 1000.
- Level/reset: hold irq_in[1] high → only one pending set. Assert reset (low) in SVC → all outputs 0 next edge; no request after release.
- TIMER_IRQ_EN: TIMER_PERIOD=8, mask bit 4 set → pending[4] sets every 8 cycles; vector=1016; timer loses to a simultaneous irq_in[0].

Source files
------------

// File: rtl/interrupt_controller.sv
// ----------------------------------------------------------------------------
// interrupt_controller
//
// Purpose:
//   Collects external interrupt lines, edge-detects them into a pending
//   register, applies a CPU-writable mask and presents the highest-priority
//   eligible source to the control unit. The selected source is held (no
//   nesting) until the control unit signals handler completion.
//
// Optional feature (macro TIMER_IRQ_EN):
//   Adds a free-running 0..TIMER_PERIOD-1 counter whose wrap sets an extra,
//   lowest-priority pending bit (index NUM_IRQ). Without the macro there is
//   no counter and no extra mask/pending bit.
//
// Ports:
//   clk             - system clock, all state updates on rising edge
//   reset           - synchronous active-low reset
//   irq_in          - external interrupt lines (asynchronous origin)
//   mask_we         - mask register write strobe
//   mask_data       - new mask value, 1 = source enabled
//   int_ack         - control unit entered its interrupt entry (REQ -> SVC)
//   s_finish_interr - control unit is returning from interrupt (SVC -> IDLE)
//   s_interruption  - registered interrupt request to the control unit
//   int_vector      - registered handler address for the PC mux
//   pending         - pending register readback
// ----------------------------------------------------------------------------
module interrupt_controller #(
    parameter int unsigned NUM_IRQ      = 4,
    parameter int unsigned PC_W         = 10,
    parameter int unsigned VEC_BASE     = 1000,
    parameter int unsigned VEC_STRIDE   = 4,
    parameter int unsigned TIMER_PERIOD = 1000,
`ifdef TIMER_IRQ_EN
    localparam int unsigned NUM_SRC     = NUM_IRQ + 1
`else
    localparam int unsigned NUM_SRC     = NUM_IRQ
`endif
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_IRQ-1:0]  irq_in,
    input  logic                mask_we,
    input  logic [NUM_SRC-1:0]  mask_data,
    input  logic                int_ack,
    input  logic                s_finish_interr,
    output logic                s_interruption,
    output logic [PC_W-1:0]     int_vector,
    output logic [NUM_SRC-1:0]  pending
);

    localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    // Reject configurations outside the supported range at elaboration.
    if (NUM_IRQ < 1 || NUM_IRQ > 8 || TIMER_PERIOD < 1) begin : g_param_check
        $error("interrupt_controller: unsupported parameter value");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SVC  = 2'd2
    } state_e;

    state_e                state_q;
    logic [NUM_IRQ-1:0]    sync1_q, sync2_q, sync3_q;
    logic [NUM_SRC-1:0]    pending_q, pending_d;
    logic [NUM_SRC-1:0]    mask_q, mask_d;
    logic [NUM_SRC-1:0]    set_c, clr_c, eligible_c;
    logic [NUM_IRQ-1:0]    edge_c;
    logic [IDX_W-1:0]      win_idx_c, svc_q;
    logic                  win_valid_c;
    logic                  fin_c;
    logic [PC_W-1:0]       vec_c, vec_q;
    logic                  s_int_q;

`ifdef TIMER_IRQ_EN
    localparam int unsigned TCNT_W = (TIMER_PERIOD > 1) ? $clog2(TIMER_PERIOD) : 1;

    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic              tick_c;

    // Free-running period counter; wraps regardless of the mask.
    always_comb begin
        tick_c = (tcnt_q == TCNT_W'(TIMER_PERIOD - 1));
        tcnt_d = tick_c ? '0 : tcnt_q + TCNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_d;
        end
    end
`endif

    // Rising edge seen between the second and third synchroniser stages.
    assign edge_c = sync2_q & ~sync3_q;

`ifdef TIMER_IRQ_EN
    assign set_c = {tick_c, edge_c};
`else
    assign set_c = edge_c;
`endif

    // Completion only counts while a source is in service.
    assign fin_c = (state_q == ST_SVC) && s_finish_interr;

    // Pending/mask next state; a set wins over a simultaneous clear.
    always_comb begin
        clr_c = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            clr_c[i] = fin_c && (svc_q == IDX_W'(i));
        end
        pending_d = (pending_q & ~clr_c) | set_c;
        mask_d    = mask_we ? mask_data : mask_q;
    end

    // Fixed priority: lowest eligible index wins.
    always_comb begin
        eligible_c  = pending_q & mask_q;
        win_valid_c = 1'b0;
        win_idx_c   = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (eligible_c[i]) begin
                win_valid_c = 1'b1;
                win_idx_c   = IDX_W'(i);
            end
        end
        vec_c = PC_W'(VEC_BASE + VEC_STRIDE * 32'(win_idx_c));
    end

    // Synchroniser, pending and mask registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            sync3_q   <= '0;
            pending_q <= '0;
            mask_q    <= '0;
        end else begin
            sync1_q   <= irq_in;
            sync2_q   <= sync1_q;
            sync3_q   <= sync2_q;
            pending_q <= pending_d;
            mask_q    <= mask_d;
        end
    end

    // Request FSM. s_interruption follows the state one cycle later, which
    // gives a 2-cycle pending-to-request latency and guarantees at least one
    // low cycle between consecutive requests.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            svc_q   <= '0;
            vec_q   <= '0;
            s_int_q <= 1'b0;
        end else begin
            s_int_q <= (state_q != ST_IDLE);
            case (state_q)
                ST_IDLE: begin
                    if (win_valid_c) begin
                        svc_q   <= win_idx_c;
                        vec_q   <= vec_c;
                        state_q <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (int_ack) begin
                        state_q <= ST_SVC;
                    end
                end
                ST_SVC: begin
                    if (s_finish_interr) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_interruption = s_int_q;
    assign int_vector     = vec_q;
    assign pending        = pending_q;

endmodule

// File: tb/tb_interrupt_controller.sv
module tb_interrupt_controller;

    localparam int NUM_IRQ = 4;
    localparam int PC_W    = 10;
    localparam int VB      = 1000;
    localparam int VS      = 4;
`ifdef TIMER_IRQ_EN
    localparam int NS      = NUM_IRQ + 1;
    localparam int TP      = 8;
`else
    localparam int NS      = NUM_IRQ;
    localparam int TP      = 1000;
`endif

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic [NUM_IRQ-1:0]  irq_in = '0;
    logic                mask_we = 1'b0;
    logic [NS-1:0]       mask_data = '0;
    logic                int_ack = 1'b0;
    logic                s_finish_interr = 1'b0;
    logic                s_interruption;
    logic [PC_W-1:0]     int_vector;
    logic [NS-1:0]       pending;

    interrupt_controller #(
        .NUM_IRQ      (NUM_IRQ),
        .PC_W         (PC_W),
        .VEC_BASE     (VB),
        .VEC_STRIDE   (VS),
        .TIMER_PERIOD (TP)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .irq_in          (irq_in),
        .mask_we         (mask_we),
        .mask_data       (mask_data),
        .int_ack         (int_ack),
        .s_finish_interr (s_finish_interr),
        .s_interruption  (s_interruption),
        .int_vector      (int_vector),
        .pending         (pending)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: sampled-input history plus a service phase
    // (0 = nothing selected, 1 = requesting, 2 = handler running).
    logic [NUM_IRQ-1:0] h_k1 = '0, h_k2 = '0, h_k3 = '0;
    logic [NS-1:0]      m_pend = '0, m_mask = '0;
    int                 m_phase = 0, m_svc = 0, m_vec = 0;
    logic               m_sint = 1'b0;
`ifdef TIMER_IRQ_EN
    int                 m_cycles = 0;
`endif

    task automatic model_step();
        logic [NS-1:0] set_v, elig;
        int win;
        if (!reset) begin
            h_k1 = '0; h_k2 = '0; h_k3 = '0;
            m_pend = '0; m_mask = '0;
            m_phase = 0; m_svc = 0; m_vec = 0; m_sint = 1'b0;
`ifdef TIMER_IRQ_EN
            m_cycles = 0;
`endif
            return;
        end
        set_v = '0;
        // a line sampled high two edges ago after being low three edges ago
        for (int i = 0; i < NUM_IRQ; i++) set_v[i] = h_k2[i] & ~h_k3[i];
`ifdef TIMER_IRQ_EN
        if ((m_cycles % TP) == TP - 1) set_v[NUM_IRQ] = 1'b1;
        m_cycles++;
`endif
        elig   = m_pend & m_mask;
        m_sint = (m_phase != 0);
        case (m_phase)
            0: begin
                win = -1;
                for (int i = 0; i < NS; i++) if (elig[i] && win < 0) win = i;
                if (win >= 0) begin
                    m_phase = 1;
                    m_svc   = win;
                    m_vec   = (VB + win * VS) % (1 << PC_W);
                end
            end
            1: if (int_ack) m_phase = 2;
            default: if (s_finish_interr) begin
                m_pend[m_svc] = 1'b0;
                m_phase = 0;
            end
        endcase
        m_pend = m_pend | set_v;
        h_k3 = h_k2; h_k2 = h_k1; h_k1 = irq_in;
        if (mask_we) m_mask = mask_data;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("s_interruption", 32'(s_interruption), 32'(m_sint));
        check("int_vector", 32'(int_vector), 32'(m_vec));
        check("pending", 32'(pending), 32'(m_pend));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_mask(input logic [NS-1:0] v);
        mask_we = 1'b1; mask_data = v; tick();
        mask_we = 1'b0;
    endtask

    task automatic pulse(input logic [NUM_IRQ-1:0] b);
        irq_in = irq_in | b; tick();
        irq_in = irq_in & ~b; tick();
    endtask

    task automatic wait_req(input string tag, input int exp_vec);
        int n = 0;
        while (!s_interruption && n < 40) begin
            tick();
            n++;
        end
        if (!s_interruption) check({tag, "_timeout"}, 32'(0), 32'(1));
        else check(tag, 32'(int_vector), 32'(exp_vec));
    endtask

    task automatic do_ack();
        int_ack = 1'b1; tick();
        int_ack = 1'b0;
    endtask

    task automatic do_fin();
        s_finish_interr = 1'b1; tick();
        s_finish_interr = 1'b0; tick();
        check("gap_after_finish", 32'(s_interruption), 32'(0));
    endtask

    initial begin
        // reset state
        reset = 1'b0;
        ticks(3);
        check("rst_sint", 32'(s_interruption), 32'(0));
        check("rst_vec", 32'(int_vector), 32'(0));
        check("rst_pend", 32'(pending), 32'(0));
        reset = 1'b1;
        tick();

        // basic: source 2, pending after 3 edges
        set_mask(NS'(4'b1111));
        irq_in = 4'b0100; tick();
        irq_in = 4'b0000; tick();
        check("basic_pend_early", 32'(pending[2]), 32'(0));
        tick();
        check("basic_pend", 32'(pending[2]), 32'(1));
        wait_req("basic_vec", 1008);
        do_ack();
        do_fin();
        check("basic_cleared", 32'(pending[NUM_IRQ-1:0]), 32'(0));

        // priority: 3 and 1 together
        pulse(4'b1010);
        wait_req("prio_first", 1004);
        do_ack();
        do_fin();
        wait_req("prio_second", 1012);
        do_ack();
        do_fin();

        // masking
        set_mask(NS'(4'b1110));
        pulse(4'b0001);
        ticks(6);
        check("mask_pend", 32'(pending[0]), 32'(1));
        check("mask_noreq", 32'(s_interruption), 32'(0));
        set_mask(NS'(4'b0001));
        wait_req("mask_unmask", 1000);
        do_ack();
        do_fin();

        // no nesting
        set_mask(NS'(4'b1111));
        pulse(4'b0100);
        wait_req("nest_first", 1008);
        do_ack();
        pulse(4'b0001);
        ticks(4);
        check("nest_vec_hold", 32'(int_vector), 32'(1008));
        check("nest_pend0", 32'(pending[0]), 32'(1));
        do_fin();
        wait_req("nest_next", 1000);
        do_ack();
        do_fin();

        // held level triggers once; reset mid-service
        irq_in = 4'b0010;
        wait_req("level_req", 1004);
        do_ack();
        do_fin();
        ticks(6);
        check("level_once_pend", 32'(pending[NUM_IRQ-1:0]), 32'(0));
        check("level_once_req", 32'(s_interruption), 32'(0));
        pulse(4'b0100);
        wait_req("rst_mid_req", 1008);
        do_ack();
        irq_in = '0;
        reset = 1'b0; tick();
        check("rst_mid_sint", 32'(s_interruption), 32'(0));
        check("rst_mid_vec", 32'(int_vector), 32'(0));
        check("rst_mid_pend", 32'(pending), 32'(0));
        reset = 1'b1;
        ticks(8);
        check("rst_release_noreq", 32'(s_interruption), 32'(0));

`ifdef TIMER_IRQ_EN
        set_mask(NS'(5'b10000));
        wait_req("timer_vec", 1016);
        do_ack();
        do_fin();
        set_mask(NS'(5'b00000));
        pulse(4'b0001);
        ticks(10);
        set_mask(NS'(5'b10001));
        wait_req("timer_loses", 1000);
        do_ack();
        do_fin();
        wait_req("timer_after", 1016);
        do_ack();
        do_fin();
`endif

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < NUM_IRQ; b++)
                if ($urandom_range(7) == 0) irq_in[b] = ~irq_in[b];
            mask_we         = ($urandom_range(15) == 0);
            mask_data       = NS'($urandom);
            int_ack         = ($urandom_range(2) == 0);
            s_finish_interr = ($urandom_range(3) == 0);
            reset           = ($urandom_range(399) != 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
